// File: rtl/async_fifo_write.sv
// Write-domain half of an asynchronous FIFO: storage, binary/Gray
// write pointer, registered full flag and sticky overflow flag.
module async_fifo_write #(
  parameter int D_SIZE  = 16,
  parameter int F_DEPTH = 8,
  parameter int P_SIZE  = 4
) (
  input  logic              i_w_clk,
  input  logic              i_w_rstn,
  input  logic              i_w_inc,
  input  logic [D_SIZE-1:0] i_w_data,
  input  logic [P_SIZE-1:0] gray_rd_ptr_sync,
  output logic [D_SIZE-1:0] FIFO_MEM [F_DEPTH],
  output logic              o_full,
  output logic              o_overflow,
  output logic [P_SIZE-1:0] gray_w_ptr
);

  logic [P_SIZE-1:0] w_bin;
  logic [P_SIZE-1:0] w_bin_next;
  logic [P_SIZE-1:0] w_gray_next;
  logic [P_SIZE-1:0] full_cmp;
  logic [P_SIZE-2:0] w_addr;
  logic              w_en;

  assign w_en        = i_w_inc & ~o_full;
  assign w_addr      = w_bin[P_SIZE-2:0];
  assign w_bin_next  = w_bin + P_SIZE'(w_en);
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Full when the write pointer is one lap ahead of the read pointer:
  // in Gray code that is the top two bits inverted, the rest equal.
  assign full_cmp = {~gray_rd_ptr_sync[P_SIZE-1:P_SIZE-2],
                     gray_rd_ptr_sync[P_SIZE-3:0]};

  always_ff @(posedge i_w_clk or negedge i_w_rstn) begin
    if (!i_w_rstn) begin
      w_bin      <= '0;
      gray_w_ptr <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      w_bin      <= w_bin_next;
      gray_w_ptr <= w_gray_next;
      o_full     <= (w_gray_next == full_cmp);
      if (i_w_inc && o_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rstn) begin
    if (!i_w_rstn) begin
      for (int i = 0; i < F_DEPTH; i++) begin
        FIFO_MEM[i] <= '0;
      end
    end else if (w_en) begin
      FIFO_MEM[w_addr] <= i_w_data;
    end
  end

endmodule

// File: tb/tb_async_fifo_write.sv
// Bench for async_fifo_write: scoreboard of accepted writes plus a
// binary-occupancy model of full/overflow and the Gray write pointer.
module tb_async_fifo_write;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inc;
  logic [15:0] wdata;
  logic [3:0]  rd_g;
  logic [15:0] mem [8];
  logic        full;
  logic        ovf;
  logic [3:0]  gw;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_mem [8];
  int          wbin;
  int          rbin;
  bit          m_full;
  bit          m_ovf;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  async_fifo_write #(
    .D_SIZE(16),
    .F_DEPTH(8),
    .P_SIZE(4)
  ) dut (
    .i_w_clk(clk),
    .i_w_rstn(rstn),
    .i_w_inc(inc),
    .i_w_data(wdata),
    .gray_rd_ptr_sync(rd_g),
    .FIFO_MEM(mem),
    .o_full(full),
    .o_overflow(ovf),
    .gray_w_ptr(gw)
  );

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    wbin   = 0;
    rbin   = 0;
    m_full = 0;
    m_ovf  = 0;
    sb.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    inc  = 1'b0;
    rd_g = 4'b0000;
    #2 rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic cycle(input bit w, input logic [15:0] d);
    exp_t e;
    bit   acc;
    @(negedge clk);
    inc   = w;
    wdata = d;
    rd_g  = b2g(rbin);
    acc   = w && !m_full;
    if (acc) sb.push_back('{wbin % 8, d});
    @(posedge clk);
    #1;
    if (acc) begin
      m_mem[wbin % 8] = d;
      wbin = (wbin + 1) % 16;
    end else if (w) begin
      m_ovf = 1;
    end
    m_full = (((wbin - rbin) + 16) % 16) == 8;
    if (acc) begin
      e = sb.pop_front();
      n_chk++;
      if (mem[e.addr] !== e.data)
        $display("FAIL sb_write[%0d]: got %h expected %h",
                 e.addr, mem[e.addr], e.data);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (mem[i] !== m_mem[i])
        $display("FAIL mem[%0d]: got %h expected %h",
                 i, mem[i], m_mem[i]);
      else n_pass++;
    end
    n_chk++;
    if (gw !== b2g(wbin))
      $display("FAIL gray_w_ptr: got %b expected %b", gw, b2g(wbin));
    else n_pass++;
    n_chk++;
    if (full !== m_full)
      $display("FAIL o_full: got %b expected %b", full, m_full);
    else n_pass++;
    n_chk++;
    if (ovf !== m_ovf)
      $display("FAIL o_overflow: got %b expected %b", ovf, m_ovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn  = 1'b1;
    inc   = 1'b0;
    wdata = '0;
    rd_g  = '0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (gw !== 4'b0000 || full !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_flags: got gw=%b full=%b ovf=%b expected 0000 0 0",
               gw, full, ovf);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (mem[i] !== 16'h0000)
        $display("FAIL reset_mem[%0d]: got %h expected 0000", i, mem[i]);
      else n_pass++;
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_fill();
    rbin = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 16'(i));
      if (i == 7) begin
        n_chk++;
        if (full !== 1'b0)
          $display("FAIL fill_early_full: got %b expected 0", full);
        else n_pass++;
      end
    end
    n_chk++;
    if (gw !== 4'b1100 || full !== 1'b1)
      $display("FAIL fill_end: got gw=%b full=%b expected 1100 1", gw, full);
    else n_pass++;
  endtask

  task automatic test_overflow();
    cycle(1'b1, 16'hDEAD);
    n_chk++;
    if (gw !== 4'b1100 || ovf !== 1'b1)
      $display("FAIL overflow: got gw=%b ovf=%b expected 1100 1", gw, ovf);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
    n_chk++;
    if (ovf !== 1'b1)
      $display("FAIL overflow_sticky: got %b expected 1", ovf);
    else n_pass++;
  endtask

  task automatic test_drain_refill();
    rbin = 1;
    cycle(1'b0, 16'h0);
    n_chk++;
    if (full !== 1'b0)
      $display("FAIL drain_full: got %b expected 0", full);
    else n_pass++;
    cycle(1'b1, 16'h0009);
    n_chk++;
    if (mem[0] !== 16'h0009 || gw !== 4'b1101 || full !== 1'b1)
      $display("FAIL refill: got mem0=%h gw=%b full=%b expected 0009 1101 1",
               mem[0], gw, full);
    else n_pass++;
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 1; i <= 17; i++) begin
      rbin = wbin;
      cycle(1'b1, 16'h0100 + 16'(i));
      if (i == 15) begin
        n_chk++;
        if (gw !== 4'b1000)
          $display("FAIL wrap_gray15: got %b expected 1000", gw);
        else n_pass++;
      end
      if (i == 16) begin
        n_chk++;
        if (gw !== 4'b0000)
          $display("FAIL wrap_gray0: got %b expected 0000", gw);
        else n_pass++;
      end
    end
    n_chk++;
    if (mem[0] !== 16'h0111 || full !== 1'b0)
      $display("FAIL wrap_addr0: got mem0=%h full=%b expected 0111 0",
               mem[0], full);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    rbin = 0;
    cycle(1'b1, 16'h0011);
    cycle(1'b1, 16'h0022);
    cycle(1'b1, 16'h0033);
    @(negedge clk);
    inc = 1'b0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (gw !== 4'b0000 || full !== 1'b0 || ovf !== 1'b0 ||
        mem[0] !== 16'h0 || mem[1] !== 16'h0 || mem[2] !== 16'h0)
      $display("FAIL mid_reset: got gw=%b full=%b ovf=%b m0=%h m1=%h m2=%h expected zeros",
               gw, full, ovf, mem[0], mem[1], mem[2]);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, 16'h00AA);
    n_chk++;
    if (mem[0] !== 16'h00AA || gw !== 4'b0001)
      $display("FAIL post_reset_write: got mem0=%h gw=%b expected 00aa 0001",
               mem[0], gw);
    else n_pass++;
    cycle(1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_refill();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
